// File: rtl/macro_fetch_pkg.sv
// Shared types for the macroinstruction fetch buffer: FSM states, buffer entry layout,
// and the lc byte-offset width.
package macro_fetch_pkg;

  localparam int FETCH_WAW     = 24;
  localparam int WORD_SEL_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic                 valid;
    logic [FETCH_WAW-1:0] tag;
    logic [31:0]          data;
  } buf_entry_t;

endpackage

// File: rtl/macro_fetch_buffer_mir_select.sv
// Extracts the current macroinstruction from the CUR word: a halfword by lc[1], or a
// zero-extended byte by lc[1:0] in byte mode. Drives zero when the word is not valid.
module mir_select
  import macro_fetch_pkg::*;
(
  input  logic [31:0]              data_i,
  input  logic [WORD_SEL_BITS-1:0] sel_i,
  input  logic                     byte_mode_i,
  input  logic                     valid_i,
  output logic [15:0]              mir_o
);

  logic [7:0] byte_lane [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lane[gi] = data_i[8*gi +: 8];
  end

  always_comb begin
    mir_o = 16'h0000;
    if (valid_i) begin
      if (byte_mode_i) begin
        mir_o = {8'h00, byte_lane[sel_i]};
      end else begin
        mir_o = sel_i[1] ? data_i[31:16] : data_i[15:0];
      end
    end
  end

endmodule

// File: rtl/macro_fetch_buffer.sv
// Two-entry (CUR/NXT) macroinstruction fetch buffer with one-word sequential prefetch.
// Optional MACRO_FETCH_STATS_EN adds saturating fetch/flush counters. WAW must equal FETCH_WAW.
module macro_fetch_buffer
  import macro_fetch_pkg::*;
#(
  parameter int WAW      = FETCH_WAW,
  parameter bit PREFETCH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WAW+1:0]   lc,
  input  logic             lc_byte_mode,
  output logic             mem_req,
  output logic [WAW-1:0]   mem_addr,
  input  logic             mem_ack,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic [15:0]      mir,
  output logic             mir_valid,
  output logic             needfetch
`ifdef MACRO_FETCH_STATS_EN
  ,
  output logic [15:0]      stat_fetches,
  output logic [15:0]      stat_flushes
`endif
);

  localparam logic [WAW-1:0] ONE_WORD = {{(WAW-1){1'b0}}, 1'b1};

  fetch_state_e   state_q, state_d;
  buf_entry_t     cur_q, cur_d, nxt_q, nxt_d;
  buf_entry_t     cur_a, nxt_a;
  logic [WAW-1:0] addr_q, addr_d;
  logic           drop_q, drop_d;

  logic [WAW-1:0] word_w;
  logic [WAW-1:0] cur_succ;
  logic           cur_match, nxt_match, advance, jump;

  assign word_w    = lc[WAW+1:WORD_SEL_BITS];
  assign cur_match = cur_q.valid && (cur_q.tag == word_w);
  assign nxt_match = nxt_q.valid && (nxt_q.tag == word_w);
  assign advance   = !cur_match && nxt_match;
  assign jump      = !cur_match && !nxt_match;

  // Promotion and jump invalidation are applied combinationally so a promoted NXT
  // is visible as a hit in the same cycle lc steps onto it.
  always_comb begin
    cur_a = cur_q;
    nxt_a = nxt_q;
    if (advance) begin
      cur_a       = nxt_q;
      nxt_a.valid = 1'b0;
    end else if (jump) begin
      cur_a.valid = 1'b0;
      nxt_a.valid = 1'b0;
    end
  end

  assign cur_succ  = cur_a.tag + ONE_WORD;
  assign needfetch = !(cur_a.valid && (cur_a.tag == word_w));
  assign mir_valid = !needfetch;
  assign mem_req   = (state_q == ST_REQ);
  assign mem_addr  = addr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    cur_d   = cur_a;
    nxt_d   = nxt_a;
    case (state_q)
      ST_IDLE: begin
        if (needfetch) begin
          state_d = ST_REQ;
          addr_d  = word_w;
        end else if (PREFETCH && cur_a.valid && !nxt_a.valid) begin
          state_d = ST_REQ;
          addr_d  = cur_succ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = ST_WAIT;
          if (jump && (addr_q != word_w)) drop_d = 1'b1;
        end else if (jump) begin
          addr_d = word_w;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
          if (!drop_q) begin
            if (addr_q == word_w) begin
              cur_d = '{valid: 1'b1, tag: addr_q, data: mem_rdata};
            end else if (cur_a.valid && (addr_q == cur_succ)) begin
              nxt_d = '{valid: 1'b1, tag: addr_q, data: mem_rdata};
            end
          end
        end else if (jump && (addr_q != word_w)) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      addr_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  mir_select u_mir_select (
    .data_i      (cur_a.data),
    .sel_i       (lc[WORD_SEL_BITS-1:0]),
    .byte_mode_i (lc_byte_mode),
    .valid_i     (mir_valid),
    .mir_o       (mir)
  );

`ifdef MACRO_FETCH_STATS_EN
  logic [15:0] fetches_q, flushes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetches_q <= 16'h0000;
      flushes_q <= 16'h0000;
    end else begin
      if (mem_req && mem_ack && (fetches_q != 16'hFFFF)) fetches_q <= fetches_q + 16'd1;
      if (jump && (cur_q.valid || nxt_q.valid) && (flushes_q != 16'hFFFF))
        flushes_q <= flushes_q + 16'd1;
    end
  end

  assign stat_fetches = fetches_q;
  assign stat_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_macro_fetch_buffer.sv
// Self-checking bench for macro_fetch_buffer: directed sequences, a byte/halfword
// select table, and a randomized lc walk checked against a memory-content model.
module tb_macro_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] lc;
  logic        lc_byte_mode;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [15:0] mir;
  logic        mir_valid;
  logic        needfetch;
`ifdef MACRO_FETCH_STATS_EN
  logic [15:0] stat_fetches;
  logic [15:0] stat_flushes;
`endif

  always #5 clk = ~clk;

  macro_fetch_buffer #(.WAW(24), .PREFETCH(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .lc           (lc),
    .lc_byte_mode (lc_byte_mode),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .mir          (mir),
    .mir_valid    (mir_valid),
    .needfetch    (needfetch)
`ifdef MACRO_FETCH_STATS_EN
    ,
    .stat_fetches (stat_fetches),
    .stat_flushes (stat_flushes)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Memory contents: explicit overrides, otherwise a per-address pattern.
  logic [31:0] mem_ovr [logic [23:0]];

  function automatic logic [31:0] word_of(logic [23:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C, ~a[7:0], a[23:16] ^ a[7:0]};
  endfunction

  function automatic logic [15:0] exp_mir(logic [31:0] w, logic [25:0] l, logic bm);
    logic [31:0] s;
    if (bm) begin
      s = w >> (8 * l[1:0]);
      return {8'h00, s[7:0]};
    end
    s = w >> (16 * l[1]);
    return s[15:0];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder, stepped once per cycle from the main process.
  bit          resp_en = 1'b1;
  bit          rand_dly = 1'b0;
  bit          resp_busy = 1'b0;
  int          acnt = 0;
  int          rcnt = 0;
  int          ack_dly = 1;
  int          rd_dly = 2;
  int          nacks = 0;
  logic [23:0] raddr = '0;

  task automatic resp_step();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    if (resp_busy) begin
      if (rcnt <= 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = word_of(raddr);
        resp_busy  = 1'b0;
      end else begin
        rcnt--;
      end
    end else if (mem_req) begin
      if (acnt >= ack_dly) begin
        mem_ack   = 1'b1;
        raddr     = mem_addr;
        resp_busy = 1'b1;
        nacks++;
        acnt      = 0;
        rcnt      = rand_dly ? int'($urandom_range(1, 3)) : rd_dly;
        if (rand_dly) ack_dly = int'($urandom_range(0, 2));
      end else begin
        acnt++;
      end
    end else begin
      acnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (resp_en) resp_step();
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    resp_busy  = 1'b0;
    acnt       = 0;
    nacks      = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_req(string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) begin ok = 1'b1; break; end
      tick();
    end
    check({name, "_req_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_ack(string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_ack) begin ok = 1'b1; break; end
      tick();
    end
    check({name, "_ack_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_rvalid(string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_rvalid) begin ok = 1'b1; break; end
      tick();
    end
    check({name, "_rvalid_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_hit(string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!needfetch) begin ok = 1'b1; break; end
      tick();
    end
    check({name, "_hit_timeout"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [25:0] lc;
    logic        bm;
    logic [15:0] mir;
    logic        valid;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] p_addr, p_w, last_w;
    logic        p_req, p_ack;
    int          stall;

    vecs[0] = '{26'h0000800, 1'b1, 16'h00D4, 1'b1};
    vecs[1] = '{26'h0000801, 1'b1, 16'h00C3, 1'b1};
    vecs[2] = '{26'h0000802, 1'b1, 16'h00B2, 1'b1};
    vecs[3] = '{26'h0000803, 1'b1, 16'h00A1, 1'b1};
    vecs[4] = '{26'h0000800, 1'b0, 16'hC3D4, 1'b1};
    vecs[5] = '{26'h0000803, 1'b0, 16'hA1B2, 1'b1};
    vecs[6] = '{26'h0000801, 1'b0, 16'hC3D4, 1'b1};
    vecs[7] = '{26'h0000040, 1'b0, 16'h0000, 1'b0};

    mem_ovr[24'h000004] = 32'hBEEF_1234;
    mem_ovr[24'h000200] = 32'hA1B2_C3D4;

    mem_rdata    = '0;
    lc           = 26'h0000010;
    lc_byte_mode = 1'b0;

    // Reset state
    do_reset();
    reset = 1'b1;
    tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mir", 32'(mir), 32'd0);
    check("rst_mir_valid", 32'(mir_valid), 32'd0);
    check("rst_needfetch", 32'(needfetch), 32'd1);
    reset = 1'b0;

    // Demand fetch of word 4
    wait_req("demand");
    check("demand_addr", 32'(mem_addr), 32'h4);
    check("demand_needfetch", 32'(needfetch), 32'd1);
    wait_rvalid("demand");
    check("fill_cycle_needfetch", 32'(needfetch), 32'd1);
    tick();
    check("fill_mir_valid", 32'(mir_valid), 32'd1);
    check("fill_mir_lo", 32'(mir), 32'h1234);
    lc = 26'h0000012;
    #1;
    check("fill_mir_hi", 32'(mir), 32'hBEEF);

    // Sequential prefetch and promotion
    wait_req("prefetch");
    check("prefetch_addr", 32'(mem_addr), 32'h5);
    check("prefetch_no_miss", 32'(needfetch), 32'd0);
    wait_rvalid("prefetch");
    tick();
    lc = 26'h0000014;
    #1;
    check("promote_needfetch", 32'(needfetch), 32'd0);
    check("promote_mir", 32'(mir), 32'(exp_mir(word_of(24'h5), lc, 1'b0)));
    tick();
    check("promoted_needfetch", 32'(needfetch), 32'd0);
    lc = 26'h0000016;
    #1;
    check("promoted_mir_hi", 32'(mir), 32'(exp_mir(word_of(24'h5), lc, 1'b0)));

    // Jump while waiting on word 5
    rd_dly = 4;
    lc     = 26'h0000010;
    do_reset();
    wait_hit("jump_setup");
    wait_req("jump_pf");
    check("jump_pf_addr", 32'(mem_addr), 32'h5);
    wait_ack("jump_pf");
    tick();
    lc = 26'h0000400;
    #1;
    check("jump_needfetch", 32'(needfetch), 32'd1);
    check("jump_mir", 32'(mir), 32'd0);
    wait_rvalid("jump_drop");
    tick();
    check("drop_needfetch", 32'(needfetch), 32'd1);
    wait_req("jump_demand");
    check("jump_demand_addr", 32'(mem_addr), 32'h100);
    wait_rvalid("jump_demand");
    check("jump_prefill_needfetch", 32'(needfetch), 32'd1);
    tick();
    check("jump_fill_valid", 32'(mir_valid), 32'd1);
    check("jump_fill_mir", 32'(mir), 32'(exp_mir(word_of(24'h100), lc, 1'b0)));
    rd_dly = 2;

    // Byte / halfword select table
    lc = 26'h0000800;
    #1;
    wait_hit("table");
    for (int i = 0; i < 8; i++) begin
      lc           = vecs[i].lc;
      lc_byte_mode = vecs[i].bm;
      #1;
      check($sformatf("table%0d_mir", i), 32'(mir), 32'(vecs[i].mir));
      check($sformatf("table%0d_valid", i), 32'(mir_valid), 32'(vecs[i].valid));
      check($sformatf("table%0d_needfetch", i), 32'(needfetch), 32'(!vecs[i].valid));
      tick();
    end
    lc_byte_mode = 1'b0;

    // Prefetch wraps from the top word to word 0
    lc = 26'h3FFFFFC;
    #1;
    wait_hit("wrap");
    check("wrap_mir", 32'(mir), 32'(exp_mir(word_of(24'hFFFFFF), lc, 1'b0)));
    wait_req("wrap");
    check("wrap_addr", 32'(mem_addr), 32'h0);

    // Reset while a request is in WAIT; a late response must be ignored
    resp_en = 1'b0;
    lc      = 26'h0000010;
    do_reset();
    wait_req("rstwait");
    check("rstwait_addr", 32'(mem_addr), 32'h4);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    check("rstwait_in_wait", 32'(mem_req), 32'd0);
    reset = 1'b1;
    tick();
    check("rstwait_mem_req", 32'(mem_req), 32'd0);
    check("rstwait_mem_addr", 32'(mem_addr), 32'd0);
    check("rstwait_needfetch", 32'(needfetch), 32'd1);
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0001;
    tick();
    mem_rvalid = 1'b0;
    #1;
    check("late_rvalid_mir_valid", 32'(mir_valid), 32'd0);
    check("late_rvalid_mir", 32'(mir), 32'd0);
    check("late_rvalid_new_req", 32'(mem_req), 32'd1);
    tick();
    check("late_rvalid_mir_valid2", 32'(mir_valid), 32'd0);

    // Randomized lc walk against the memory model
    resp_en  = 1'b1;
    rand_dly = 1'b1;
    ack_dly  = 0;
    lc       = 26'h0000020;
    do_reset();
    p_req  = 1'b0;
    p_ack  = 1'b0;
    p_addr = '0;
    p_w    = lc[25:2];
    last_w = lc[25:2];
    stall  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (resp_busy && !mem_ack) check("one_outstanding", 32'(mem_req), 32'd0);
      if (p_req && !p_ack) begin
        check("req_held", 32'(mem_req), 32'd1);
        if (mem_req && (mem_addr != p_addr)) check("retarget_addr", 32'(mem_addr), 32'(p_w));
      end
      if (!(needfetch && ($urandom_range(0, 7) != 0))) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: lc = 26'(lc + 26'($urandom_range(1, 2)));
          6, 7:             lc = 26'($urandom_range(0, 255));
          8:                lc = 26'h3FFFFC0 + 26'($urandom_range(0, 63));
          default:          lc_byte_mode = ~lc_byte_mode;
        endcase
      end
      #1;
      check("rand_needfetch", 32'(needfetch), 32'(!mir_valid));
      if (mir_valid) check("rand_mir", 32'(mir), 32'(exp_mir(word_of(lc[25:2]), lc, lc_byte_mode)));
      else           check("rand_mir_zero", 32'(mir), 32'd0);
      if (lc[25:2] != last_w) begin
        last_w = lc[25:2];
        stall  = 0;
      end
      if (needfetch) stall++;
      else           stall = 0;
      if (stall > 25) begin
        check("fill_latency", 32'(stall), 32'd25);
        stall = 0;
      end
      p_req  = mem_req;
      p_ack  = mem_ack;
      p_addr = mem_addr;
      p_w    = lc[25:2];
    end
`ifdef MACRO_FETCH_STATS_EN
    check("stat_fetches", 32'(stat_fetches), 32'(nacks));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
